bus_xfer_sequencer: RTL and testbench

Sequences register-to-register and immediate-to-register transfers over the shared 32-bit datapath bus. It accepts transfer commands through a valid/ready port and buffers them in a 2-entry FIFO. For each command it generates the one-hot bus-driver select (Rout / immediate drive) and the destination register enable (Rin) with the correct ordering, so only one source ever drives the bus. It sits between the control unit (or a testbench) and the DataPath register file and bus mux.

---
 rtl/bus_xfer_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_sequencer.sv
// bus_xfer_sequencer: accepts register/immediate transfer commands through a
// 2-entry FIFO and sequences bus-driver select (rout / imm_drive) followed by
// the destination load enable (rin) so that only one source drives the bus.
// Optional feature macro: BUS_XFER_COUNT_EN adds the xfer_count[15:0] output.
module bus_xfer_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int DATA_W   = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IDX_W-1:0]    cmd_src,
    input  logic [IDX_W-1:0]    cmd_dst,
    input  logic                cmd_imm_sel,
    input  logic [DATA_W-1:0]   cmd_imm,
    output logic [NUM_REGS-1:0] rout,
    output logic                imm_drive,
    output logic [DATA_W-1:0]   imm_out,
    output logic [NUM_REGS-1:0] rin,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef BUS_XFER_COUNT_EN
    ,
    output logic [15:0]         xfer_count
`endif
);

    typedef struct packed {
        logic [IDX_W-1:0]  src;
        logic [IDX_W-1:0]  dst;
        logic              imm_sel;
        logic [DATA_W-1:0] imm;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WRITE
    } state_t;

    state_t              state_q, state_d;
    entry_t              cur_q, cur_d;
    entry_t              fifo_mem_q [2];
    entry_t              fifo_mem_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [NUM_REGS-1:0] rout_q, rout_d;
    logic [NUM_REGS-1:0] rin_q, rin_d;
    logic                imm_drive_q, imm_drive_d;
    logic [DATA_W-1:0]   imm_out_q, imm_out_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    entry_t              head;
`ifdef BUS_XFER_COUNT_EN
    logic [15:0]         xfer_count_q, xfer_count_d;
`endif

    // An entry is executable only if every index it uses names a real register.
    function automatic logic entry_ok(input entry_t e);
        logic [31:0] s;
        logic [31:0] d;
        s = 32'(e.src);
        d = 32'(e.dst);
        entry_ok = (d < NUM_REGS) && (e.imm_sel || (s < NUM_REGS));
    endfunction

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];

    // FIFO storage, pointers and occupancy; a pop and a push may share a cycle.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = '{src: cmd_src, dst: cmd_dst,
                                     imm_sel: cmd_imm_sel, imm: cmd_imm};
            wr_ptr_d = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

    // Next-state logic: pop in IDLE or at the end of WRITE, reject invalid entries.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    cur_d = head;
                    if (entry_ok(head)) state_d = DRIVE;
                    else                err_d   = 1'b1;
                end
            end
            DRIVE: begin
                state_d = WRITE;
            end
            WRITE: begin
                done_d = 1'b1;
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    cur_d = head;
                    if (entry_ok(head)) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus controls are decoded from the next state and registered, so the
    // outputs come straight from flops and cannot glitch.
    always_comb begin
        rout_d      = '0;
        rin_d       = '0;
        imm_drive_d = 1'b0;
        imm_out_d   = '0;
        if (state_d == DRIVE || state_d == WRITE) begin
            if (cur_d.imm_sel) begin
                imm_drive_d = 1'b1;
                imm_out_d   = cur_d.imm;
            end else begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (cur_d.src == IDX_W'(i)) rout_d[i] = 1'b1;
                end
            end
        end
        if (state_d == WRITE) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (cur_d.dst == IDX_W'(i)) rin_d[i] = 1'b1;
            end
        end
    end

`ifdef BUS_XFER_COUNT_EN
    // Completed-transfer counter; wraps naturally at 16 bits.
    always_comb begin
        xfer_count_d = xfer_count_q + 16'(done_d);
    end
`endif

    // State, FIFO and output registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            fifo_mem_q  <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            rout_q      <= '0;
            rin_q       <= '0;
            imm_drive_q <= 1'b0;
            imm_out_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef BUS_XFER_COUNT_EN
            xfer_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rout_q      <= rout_d;
            rin_q       <= rin_d;
            imm_drive_q <= imm_drive_d;
            imm_out_q   <= imm_out_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef BUS_XFER_COUNT_EN
            xfer_count_q <= xfer_count_d;
`endif
        end
    end

    assign rout      = rout_q;
    assign rin       = rin_q;
    assign imm_drive = imm_drive_q;
    assign imm_out   = imm_out_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;
`ifdef BUS_XFER_COUNT_EN
    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Self-checking bench for bus_xfer_sequencer (NUM_REGS=12 so that
// out-of-range indices exist). Expected transfers are queued on push and
// matched when the DUT raises rin or err; a small register-file model follows
// the bus to check the data that each transfer moves.
module tb_bus_xfer_sequencer;

    localparam int NR = 12;
    localparam int IW = 4;
    localparam int DW = 32;

    logic          clock;
    logic          clear;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_src;
    logic [IW-1:0] cmd_dst;
    logic          cmd_imm_sel;
    logic [DW-1:0] cmd_imm;
    logic [NR-1:0] rout;
    logic          imm_drive;
    logic [DW-1:0] imm_out;
    logic [NR-1:0] rin;
    logic          busy;
    logic          done;
    logic          err;
`ifdef BUS_XFER_COUNT_EN
    logic [15:0]   xfer_count;
`endif

    bus_xfer_sequencer #(
        .NUM_REGS(NR),
        .IDX_W   (IW),
        .DATA_W  (DW)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src    (cmd_src),
        .cmd_dst    (cmd_dst),
        .cmd_imm_sel(cmd_imm_sel),
        .cmd_imm    (cmd_imm),
        .rout       (rout),
        .imm_drive  (imm_drive),
        .imm_out    (imm_out),
        .rin        (rin),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef BUS_XFER_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    typedef struct {
        logic [IW-1:0] src;
        logic [IW-1:0] dst;
        logic          imm_sel;
        logic [DW-1:0] imm;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic          is_err;
        logic [NR-1:0] rout;
        logic [NR-1:0] rin;
        logic          imm_drive;
        logic [DW-1:0] imm;
    } exp_t;

    exp_t          sb[$];
    int            done_cycles[$];
    vec_t          vecs[10];
    logic [DW-1:0] regs[NR];
    int            n_checks;
    int            n_fail;
    int            cycle;
    int            done_seen;
    int            done_since_clear;
    int            err_seen;
    int            exp_done;
    int            exp_err;
    logic [NR-1:0] prev_rout;
    logic          prev_imm_drive;
    logic          saw_not_ready;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Observe one sampled cycle: invariants, scoreboard matching, model update.
    task automatic monitor();
        exp_t          e;
        logic [DW-1:0] bus;
        chk("drive_onehot", 64'($countones({rout, imm_drive}) <= 1), 1);
        chk("rin_without_drive", 64'((rin != '0) && (rout == '0) && !imm_drive), 0);
        if (err) begin
            err_seen++;
            chk("err_quiet_bus", 64'({rout, rin, imm_drive} != '0), 0);
            if (sb.size() == 0) begin
                chk("err_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("err_kind", 64'(e.is_err), 1);
            end
        end
        if (rin != '0) begin
            if (sb.size() == 0) begin
                chk("rin_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("xfer_kind", 64'(e.is_err), 0);
                chk("xfer_rin", 64'(rin), 64'(e.rin));
                chk("xfer_rout", 64'(rout), 64'(e.rout));
                chk("xfer_imm_drive", 64'(imm_drive), 64'(e.imm_drive));
                if (e.imm_drive) chk("xfer_imm_out", 64'(imm_out), 64'(e.imm));
                chk("drive_held", 64'({prev_rout, prev_imm_drive}), 64'({rout, imm_drive}));
            end
            bus = imm_drive ? imm_out : '0;
            for (int k = 0; k < NR; k++) if (rout[k]) bus = regs[k];
            for (int k = 0; k < NR; k++) if (rin[k]) regs[k] = bus;
        end
        if (done) begin
            done_seen++;
            done_since_clear++;
            done_cycles.push_back(cycle);
        end
        prev_rout      = rout;
        prev_imm_drive = imm_drive;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cycle++;
        monitor();
    endtask

    // Present a command and hold it until accepted; cmd_valid is left high so
    // consecutive calls form a back-to-back stream.
    task automatic push_cmd(input vec_t v);
        logic          accepted;
        exp_t          e;
        logic [NR-1:0] one;
        cmd_src     = v.src;
        cmd_dst     = v.dst;
        cmd_imm_sel = v.imm_sel;
        cmd_imm     = v.imm;
        cmd_valid   = 1'b1;
        accepted    = 1'b0;
        for (int w = 0; w < 20 && !accepted; w++) begin
            accepted = cmd_ready;
            if (!cmd_ready) saw_not_ready = 1'b1;
            step();
        end
        if (!accepted) begin
            chk("push_timeout", 0, 1);
        end else begin
            one         = 1;
            e.is_err    = v.exp_err;
            e.imm_drive = v.imm_sel;
            e.imm       = v.imm;
            e.rout      = v.imm_sel ? '0 : (one << v.src);
            e.rin       = one << v.dst;
            sb.push_back(e);
            if (v.exp_err) exp_err++;
            else           exp_done++;
        end
    endtask

    task automatic wait_idle();
        cmd_valid = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (!busy && sb.size() == 0) break;
            step();
        end
        step();
        step();
        chk("idle_reached", 64'(busy), 0);
        chk("sb_drained", 64'(sb.size()), 0);
        chk("done_count", 64'(done_seen), 64'(exp_done));
        chk("err_count", 64'(err_seen), 64'(exp_err));
    endtask

    function automatic vec_t mk(input logic [IW-1:0] s, input logic [IW-1:0] d,
                                input logic i, input logic [DW-1:0] m, input logic e);
        mk = '{src: s, dst: d, imm_sel: i, imm: m, exp_err: e};
    endfunction

    initial begin
        int db;
        int d0;
        n_checks = 0; n_fail = 0; cycle = 0;
        done_seen = 0; done_since_clear = 0; err_seen = 0;
        exp_done = 0; exp_err = 0;
        prev_rout = '0; prev_imm_drive = 1'b0; saw_not_ready = 1'b0;
        for (int k = 0; k < NR; k++) regs[k] = '0;

        // burst of valid transfers, then a mix with rejected entries
        vecs[0] = mk(4'd0,  4'd5,  1'b1, 32'hDEAD_BEEF, 1'b0);
        vecs[1] = mk(4'd5,  4'd11, 1'b0, 32'h0,         1'b0);
        vecs[2] = mk(4'd11, 4'd0,  1'b0, 32'h0,         1'b0);
        vecs[3] = mk(4'd3,  4'd3,  1'b0, 32'h0,         1'b0);
        vecs[4] = mk(4'd15, 4'd7,  1'b1, 32'h0000_1234, 1'b0);
        vecs[5] = mk(4'd3,  4'd13, 1'b0, 32'h0,         1'b1);
        vecs[6] = mk(4'd12, 4'd4,  1'b0, 32'h0,         1'b1);
        vecs[7] = mk(4'd0,  4'd12, 1'b1, 32'h7777_7777, 1'b1);
        vecs[8] = mk(4'd11, 4'd10, 1'b0, 32'h0,         1'b0);
        vecs[9] = mk(4'd0,  4'd9,  1'b1, 32'h0000_0099, 1'b0);

        cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_imm_sel = 1'b0; cmd_imm = '0;
        clear = 1'b1;
        step();
        step();
        chk("rst_cmd_ready", 64'(cmd_ready), 1);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_rout", 64'(rout), 0);
        chk("rst_rin", 64'(rin), 0);
        chk("rst_imm_drive", 64'(imm_drive), 0);
        chk("rst_imm_out", 64'(imm_out), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        clear = 1'b0;
        step();

        // immediate load with exact latency: E0 push, E1 DRIVE, E2 WRITE, E3 done
        push_cmd(mk(4'd0, 4'd1, 1'b1, 32'd186, 1'b0));
        cmd_valid = 1'b0;
        step();
        chk("imm_e1_drive", 64'(imm_drive), 1);
        chk("imm_e1_value", 64'(imm_out), 186);
        chk("imm_e1_rin", 64'(rin), 0);
        chk("imm_e1_rout", 64'(rout), 0);
        step();
        chk("imm_e2_rin", 64'(rin), 64'h002);
        chk("imm_e2_drive", 64'(imm_drive), 1);
        step();
        chk("imm_e3_done", 64'(done), 1);
        chk("imm_e3_rin", 64'(rin), 0);
        chk("imm_e3_drive", 64'(imm_drive), 0);
        step();
        chk("imm_e4_done", 64'(done), 0);
        chk("r1_value", 64'(regs[1]), 186);

        // register copy R1 -> R2
        push_cmd(mk(4'd1, 4'd2, 1'b0, 32'h0, 1'b0));
        cmd_valid = 1'b0;
        step();
        chk("copy_e1_rout", 64'(rout), 64'h002);
        chk("copy_e1_rin", 64'(rin), 0);
        step();
        chk("copy_e2_rout", 64'(rout), 64'h002);
        chk("copy_e2_rin", 64'(rin), 64'h004);
        step();
        chk("copy_e3_done", 64'(done), 1);
        chk("copy_e3_rout", 64'(rout), 0);
        wait_idle();
        chk("r2_value", 64'(regs[2]), 186);

        // back-to-back burst: done every 2 cycles, FIFO fills
        db = done_cycles.size();
        saw_not_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(vecs[i]);
        wait_idle();
        chk("burst_ready_dropped", 64'(saw_not_ready), 1);
        chk("burst_done_pulses", 64'(done_cycles.size() - db), 5);
        for (int i = db + 1; i < done_cycles.size(); i++)
            chk("burst_done_spacing", 64'(done_cycles[i] - done_cycles[i-1]), 2);
        chk("r11_value", 64'(regs[11]), 64'hDEAD_BEEF);
        chk("r0_value", 64'(regs[0]), 64'hDEAD_BEEF);
        chk("r7_value", 64'(regs[7]), 64'h1234);

        // mixed stream with invalid indices
        for (int i = 5; i < 10; i++) push_cmd(vecs[i]);
        wait_idle();
        chk("r10_value", 64'(regs[10]), 64'hDEAD_BEEF);
        chk("r9_value", 64'(regs[9]), 64'h99);

        // single invalid command from idle: err one cycle after the pop, no done
        d0 = done_seen;
        push_cmd(mk(4'd3, 4'd13, 1'b0, 32'h0, 1'b1));
        cmd_valid = 1'b0;
        step();
        chk("inv_err", 64'(err), 1);
        chk("inv_bus", 64'({rout, rin, imm_drive}), 0);
        step();
        chk("inv_err_once", 64'(err), 0);
        chk("inv_busy", 64'(busy), 0);
        chk("inv_no_done", 64'(done_seen), 64'(d0));
        push_cmd(mk(4'd0, 4'd4, 1'b1, 32'hA5A5_0004, 1'b0));
        wait_idle();
        chk("r4_value", 64'(regs[4]), 64'hA5A5_0004);

        // clear during WRITE with a second command queued
        push_cmd(mk(4'd0, 4'd6, 1'b1, 32'h55, 1'b0));
        push_cmd(mk(4'd0, 4'd8, 1'b1, 32'h66, 1'b0));
        cmd_valid = 1'b0;
        for (int w = 0; w < 10 && rin == '0; w++) step();
        chk("abort_write_reached", 64'(rin != '0), 1);
        d0 = done_seen;
        clear = 1'b1;
        step();
        chk("abort_rin", 64'(rin), 0);
        chk("abort_rout", 64'(rout), 0);
        chk("abort_imm_drive", 64'(imm_drive), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_ready", 64'(cmd_ready), 1);
        chk("abort_busy", 64'(busy), 0);
        clear = 1'b0;
        sb.delete();
        done_since_clear = 0;
        exp_done -= 2;
        step();
        step();
        step();
        chk("abort_no_done", 64'(done_seen), 64'(d0));
        chk("abort_stays_idle", 64'(busy), 0);

        // recovery after abort
        push_cmd(mk(4'd0, 4'd9, 1'b1, 32'hCAFE_0009, 1'b0));
        wait_idle();
        chk("r9_after_abort", 64'(regs[9]), 64'hCAFE_0009);
`ifdef BUS_XFER_COUNT_EN
        chk("xfer_count", 64'(xfer_count), 64'(done_since_clear));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
